// File: rtl/dll_mq_pkg.sv
// ============================================================================
//  Module      : dll_mq_pkg
//  Description : Shared types and default sizes for the multi-queue doubly
//                linked list (dll_mq).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dll_mq_pkg;

    // Default sizing of the list pool
    localparam int c_id_n  = 4;
    localparam int c_ptr_n = 256;
    localparam int c_w     = 32;

    typedef enum logic [2:0] {
        OP_POP_FRONT  = 3'd0,
        OP_POP_BACK   = 3'd1,
        OP_PUSH_FRONT = 3'd2,
        OP_PUSH_BACK  = 3'd3,
        OP_DELETE     = 3'd4
    } op_t;

    typedef logic [$clog2(c_id_n)-1:0]  id_t;
    typedef logic [$clog2(c_ptr_n)-1:0] ptr_t;
    typedef logic [$clog2(c_ptr_n)-1:0] cnt_t;
    typedef logic [c_w-1:0]             word_t;

    typedef struct packed {
        logic valid;
        ptr_t head;
        ptr_t tail;
        cnt_t cnt;
    } queue_t;

    typedef struct packed {
        ptr_t next;
        ptr_t prev;
    } ptr_pair_t;

    typedef struct packed {
        op_t   op;
        id_t   id;
        word_t dat;
        ptr_t  ptr;
    } cmd_t;

    typedef struct packed {
        logic  err;
        word_t dat;
        ptr_t  ptr;
    } rsp_t;

endpackage

`default_nettype wire

// File: rtl/dll_mq_if.sv
// ============================================================================
//  Module      : dll_mq_if
//  Description : Command / response / status bundle of dll_mq. The master
//                side issues commands, the slave side is the list itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dll_mq_if #(
    parameter int ID_N  = 4,
    parameter int PTR_N = 256,
    parameter int W     = 32
);
    localparam int IW = $clog2(ID_N);
    localparam int PW = $clog2(PTR_N);

    logic                cmd_vld;
    logic                cmd_rdy;
    logic [2:0]          cmd_op;
    logic [IW-1:0]       cmd_id;
    logic [W-1:0]        cmd_dat;
    logic [PW-1:0]       cmd_ptr;
    logic                rsp_vld;
    logic                rsp_err;
    logic [W-1:0]        rsp_dat;
    logic [PW-1:0]       rsp_ptr;
    logic [ID_N-1:0]     empty_r;
    logic                full_r;
    logic [ID_N*PW-1:0]  cnt_r;

    modport master (
        output cmd_vld, cmd_op, cmd_id, cmd_dat, cmd_ptr,
        input  cmd_rdy, rsp_vld, rsp_err, rsp_dat, rsp_ptr, empty_r, full_r, cnt_r
    );

    modport slave (
        input  cmd_vld, cmd_op, cmd_id, cmd_dat, cmd_ptr,
        output cmd_rdy, rsp_vld, rsp_err, rsp_dat, rsp_ptr, empty_r, full_r, cnt_r
    );

endinterface

`default_nettype wire

// File: rtl/dll_mq_free_list.sv
// ============================================================================
//  Module      : dll_mq_free_list
//  Description : Free bitmap for pool entries 1..PTR_N-1 (entry 0 is NULL and
//                never allocated). Offers the lowest-index free entry, takes
//                one allocate or release per cycle, and flags full.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dll_mq_free_list #(
    parameter int PTR_N = 256
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     alloc_en,
    input  wire logic                     rel_en,
    input  wire logic [$clog2(PTR_N)-1:0] rel_ptr,
    output logic      [$clog2(PTR_N)-1:0] alloc_ptr,
    output logic                          full,
    output logic      [PTR_N-1:0]         free_vec
);
    localparam int PW = $clog2(PTR_N);

    logic [PTR_N-1:1] r_free;

    // Lowest-index free entry; 0 when the pool is exhausted
    always_comb begin
        alloc_ptr = '0;
        for (int i = PTR_N - 1; i >= 1; i--) begin
            if (r_free[i]) alloc_ptr = PW'(i);
        end
    end

    assign full     = ~|r_free;
    assign free_vec = {r_free, 1'b0};

    // Bitmap update: allocate clears the offered entry, release sets it back
    always_ff @(posedge clk) begin
        if (rst) begin
            r_free <= '1;
        end else begin
            for (int i = 1; i < PTR_N; i++) begin
                if (alloc_en && (alloc_ptr == PW'(i))) r_free[i] <= 1'b0;
                if (rel_en   && (rel_ptr   == PW'(i))) r_free[i] <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dll_mq.sv
// ============================================================================
//  Module      : dll_mq
//  Description : ID_N logical deques sharing a pool of PTR_N-1 linked entries.
//                Push/pop at either end; optional removal of any entry by
//                pointer. One command every three cycles (IDLE/LINK/COMMIT).
//  Config      : DLL_MQ_DELETE_EN - enables DELETE and the owner table.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dll_mq
    import dll_mq_pkg::*;
#(
    parameter int ID_N  = c_id_n,
    parameter int PTR_N = c_ptr_n,
    parameter int W     = c_w
) (
    input  wire logic clk,
    input  wire logic rst,
    dll_mq_if.slave   bus
);
    localparam int IW = $clog2(ID_N);
    localparam int PW = $clog2(PTR_N);
    localparam int CW = PW;
    localparam logic [CW-1:0] c_cnt_one = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LINK   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    typedef struct packed {
        logic          valid;
        logic [PW-1:0] head;
        logic [PW-1:0] tail;
        logic [CW-1:0] cnt;
    } q_entry_t;

    typedef struct packed {
        logic [PW-1:0] next;
        logic [PW-1:0] prev;
    } link_t;

    state_t          r_state, w_state_nxt;
    logic            w_cmd_rdy, w_link, w_commit;

    // Latched command
    op_t             r_op;
    logic [IW-1:0]   r_id;
    logic [W-1:0]    r_wdat;
    logic [PW-1:0]   r_cptr;

    // List storage
    q_entry_t        r_q    [ID_N];
    link_t           r_link [PTR_N];
    logic [W-1:0]    r_dat  [PTR_N];
`ifdef DLL_MQ_DELETE_EN
    logic [IW-1:0]   r_owner [PTR_N];
`endif

    // Values captured in LINK, consumed in COMMIT
    logic            r_err;
    logic [PW-1:0]   r_p, r_n, r_pr;

    logic            r_rsp_vld, r_rsp_err;
    logic [W-1:0]    r_rsp_dat;
    logic [PW-1:0]   r_rsp_ptr;

    logic            w_err, w_push;
    logic [PW-1:0]   w_p;
    logic [PW-1:0]   w_alloc_ptr;
    logic            w_full;
    logic [PTR_N-1:0] w_free_vec;
    logic            w_upd;

    dll_mq_free_list #(.PTR_N(PTR_N)) u_free_list (
        .clk       (clk),
        .rst       (rst),
        .alloc_en  (w_upd &  w_push),
        .rel_en    (w_upd & ~w_push),
        .rel_ptr   (r_p),
        .alloc_ptr (w_alloc_ptr),
        .full      (w_full),
        .free_vec  (w_free_vec)
    );

`ifndef DLL_MQ_DELETE_EN
    // Free bitmap and target pointer only matter to DELETE
    logic w_unused;
    assign w_unused = ^{w_free_vec, r_cptr};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and phase strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_rdy   = 1'b0;
        w_link      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_rdy = 1'b1;
                if (bus.cmd_vld) w_state_nxt = S_LINK;
            end
            S_LINK: begin
                w_link      = 1'b1;
                w_state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_upd = w_commit & ~r_err;

    // Capture the command on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= OP_POP_FRONT;
            r_id   <= '0;
            r_wdat <= '0;
            r_cptr <= '0;
        end else if (w_cmd_rdy && bus.cmd_vld) begin
            r_op   <= op_t'(bus.cmd_op);
            r_id   <= bus.cmd_id;
            r_wdat <= bus.cmd_dat;
            r_cptr <= bus.cmd_ptr;
        end
    end

    // Decode: target entry and rejection conditions for the latched command
    always_comb begin
        w_err  = 1'b1;
        w_p    = '0;
        w_push = 1'b0;
        case (r_op)
            OP_POP_FRONT: begin
                w_err = ~r_q[r_id].valid;
                w_p   = r_q[r_id].head;
            end
            OP_POP_BACK: begin
                w_err = ~r_q[r_id].valid;
                w_p   = r_q[r_id].tail;
            end
            OP_PUSH_FRONT, OP_PUSH_BACK: begin
                w_err  = w_full;
                w_p    = w_alloc_ptr;
                w_push = 1'b1;
            end
`ifdef DLL_MQ_DELETE_EN
            OP_DELETE: begin
                w_err = (r_cptr == '0) || w_free_vec[r_cptr] || (r_owner[r_cptr] != r_id);
                w_p   = r_cptr;
            end
`endif
            default: w_err = 1'b1;
        endcase
    end

    // LINK: register the response and the neighbours of the target entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_vld <= 1'b0;
            r_rsp_err <= 1'b0;
            r_rsp_dat <= '0;
            r_rsp_ptr <= '0;
            r_err     <= 1'b0;
            r_p       <= '0;
            r_n       <= '0;
            r_pr      <= '0;
        end else if (w_link) begin
            r_rsp_vld <= 1'b1;
            r_rsp_err <= w_err;
            r_rsp_dat <= (w_err || w_push) ? '0 : r_dat[w_p];
            r_rsp_ptr <= w_err ? '0 : w_p;
            r_err     <= w_err;
            r_p       <= w_p;
            r_n       <= r_link[w_p].next;
            r_pr      <= r_link[w_p].prev;
        end else begin
            r_rsp_vld <= 1'b0;
            r_rsp_err <= 1'b0;
            r_rsp_dat <= '0;
            r_rsp_ptr <= '0;
        end
    end

    // COMMIT: link a new entry in, or unlink the target entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ID_N; i++) r_q[i] <= '0;
            for (int i = 0; i < PTR_N; i++) begin
                r_link[i] <= '0;
                r_dat[i]  <= '0;
`ifdef DLL_MQ_DELETE_EN
                r_owner[i] <= '0;
`endif
            end
        end else if (w_upd) begin
            if (w_push) begin
                r_dat[r_p] <= r_wdat;
`ifdef DLL_MQ_DELETE_EN
                r_owner[r_p] <= r_id;
`endif
                r_q[r_id].cnt <= r_q[r_id].cnt + c_cnt_one;
                if (!r_q[r_id].valid) begin
                    r_q[r_id].valid <= 1'b1;
                    r_q[r_id].head  <= r_p;
                    r_q[r_id].tail  <= r_p;
                    r_link[r_p]     <= '0;
                end else if (r_op == OP_PUSH_FRONT) begin
                    r_link[r_q[r_id].head].prev <= r_p;
                    r_link[r_p].next            <= r_q[r_id].head;
                    r_link[r_p].prev            <= '0;
                    r_q[r_id].head              <= r_p;
                end else begin
                    r_link[r_q[r_id].tail].next <= r_p;
                    r_link[r_p].prev            <= r_q[r_id].tail;
                    r_link[r_p].next            <= '0;
                    r_q[r_id].tail              <= r_p;
                end
            end else begin
                // Pops are the end cases of a generic unlink
                r_q[r_id].cnt <= r_q[r_id].cnt - c_cnt_one;
                if (r_q[r_id].cnt == c_cnt_one) r_q[r_id].valid <= 1'b0;
                if (r_pr != '0) r_link[r_pr].next <= r_n;
                else            r_q[r_id].head    <= r_n;
                if (r_n != '0)  r_link[r_n].prev  <= r_pr;
                else            r_q[r_id].tail    <= r_pr;
            end
        end
    end

    generate
        for (genvar g = 0; g < ID_N; g++) begin : g_status
            assign bus.empty_r[g]           = ~r_q[g].valid;
            assign bus.cnt_r[g*CW +: CW]    = r_q[g].cnt;
        end
    endgenerate

    assign bus.cmd_rdy = w_cmd_rdy;
    assign bus.full_r  = w_full;
    assign bus.rsp_vld = r_rsp_vld;
    assign bus.rsp_err = r_rsp_err;
    assign bus.rsp_dat = r_rsp_dat;
    assign bus.rsp_ptr = r_rsp_ptr;

endmodule

`default_nettype wire

// File: tb/tb_dll_mq.sv
// ============================================================================
//  Module      : tb_dll_mq
//  Description : Directed self-checking bench for dll_mq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dll_mq;
    import dll_mq_pkg::*;

    localparam logic [31:0] c_a = 32'hAAAA_0001;
    localparam logic [31:0] c_b = 32'hBBBB_0002;
    localparam logic [31:0] c_c = 32'hCCCC_0003;

    logic clk;
    logic rst;

    int n_chk  = 0;
    int n_fail = 0;

    logic        got_err;
    logic [31:0] got_dat;
    logic [7:0]  got_ptr;
    int          got_lat;

    dll_mq_if #(.ID_N(4), .PTR_N(256), .W(32)) bus ();

    dll_mq #(.ID_N(4), .PTR_N(256), .W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and collect its response; returns at the first
    // negedge after COMMIT, when flags reflect the command.
    task automatic do_cmd(input op_t op, input logic [1:0] id,
                          input logic [31:0] dat, input logic [7:0] ptr);
        int n;
        n = 0;
        while (!bus.cmd_rdy && n < 20) begin @(negedge clk); n++; end
        if (!bus.cmd_rdy) check("rdy_timeout", 64'd0, 64'd1);
        bus.cmd_vld = 1'b1;
        bus.cmd_op  = op;
        bus.cmd_id  = id;
        bus.cmd_dat = dat;
        bus.cmd_ptr = ptr;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_vld = 1'b0;
        n = 0;
        while (!bus.rsp_vld && n < 20) begin @(negedge clk); n++; end
        if (!bus.rsp_vld) check("rsp_timeout", 64'd0, 64'd1);
        got_lat = n;
        got_err = bus.rsp_err;
        got_dat = bus.rsp_dat;
        got_ptr = bus.rsp_ptr;
        @(negedge clk);
    endtask

    task automatic expect_rsp(input string tag, input logic err,
                              input logic [31:0] dat, input logic [7:0] ptr);
        check({tag, "_err"}, 64'(got_err), 64'(err));
        check({tag, "_dat"}, 64'(got_dat), 64'(dat));
        check({tag, "_ptr"}, 64'(got_ptr), 64'(ptr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.cmd_vld = 1'b0;
        bus.cmd_op  = '0;
        bus.cmd_id  = '0;
        bus.cmd_dat = '0;
        bus.cmd_ptr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_rdy",   64'(bus.cmd_rdy), 64'd1);
        check("rst_vld",   64'(bus.rsp_vld), 64'd0);
        check("rst_err",   64'(bus.rsp_err), 64'd0);
        check("rst_dat",   64'(bus.rsp_dat), 64'd0);
        check("rst_ptr",   64'(bus.rsp_ptr), 64'd0);
        check("rst_empty", 64'(bus.empty_r), 64'hF);
        check("rst_full",  64'(bus.full_r),  64'd0);
        check("rst_cnt",   64'(bus.cnt_r),   64'd0);

        // 1: FIFO behaviour through push_back / pop_front
        do_cmd(OP_PUSH_BACK, 2'd0, c_a, 8'd0);
        check("t1_latency", 64'(got_lat), 64'd1);
        check("t1_vld_one_cycle", 64'(bus.rsp_vld), 64'd0);
        expect_rsp("t1_push_a", 1'b0, 32'd0, 8'd1);
        do_cmd(OP_PUSH_BACK, 2'd0, c_b, 8'd0);
        expect_rsp("t1_push_b", 1'b0, 32'd0, 8'd2);
        do_cmd(OP_PUSH_BACK, 2'd0, c_c, 8'd0);
        expect_rsp("t1_push_c", 1'b0, 32'd0, 8'd3);
        check("t1_cnt",   64'(bus.cnt_r),   64'h0000_0003);
        check("t1_empty", 64'(bus.empty_r), 64'hE);
        do_cmd(OP_POP_FRONT, 2'd0, 32'd0, 8'd0);
        expect_rsp("t1_pop_a", 1'b0, c_a, 8'd1);
        do_cmd(OP_POP_FRONT, 2'd0, 32'd0, 8'd0);
        expect_rsp("t1_pop_b", 1'b0, c_b, 8'd2);
        do_cmd(OP_POP_FRONT, 2'd0, 32'd0, 8'd0);
        expect_rsp("t1_pop_c", 1'b0, c_c, 8'd3);
        check("t1_empty_end", 64'(bus.empty_r), 64'hF);
        check("t1_cnt_end",   64'(bus.cnt_r),   64'd0);

        // 2: push_front then pop_back returns the oldest entry
        do_cmd(OP_PUSH_FRONT, 2'd1, c_a, 8'd0);
        expect_rsp("t2_push_a", 1'b0, 32'd0, 8'd1);
        do_cmd(OP_PUSH_FRONT, 2'd1, c_b, 8'd0);
        expect_rsp("t2_push_b", 1'b0, 32'd0, 8'd2);
        do_cmd(OP_POP_BACK, 2'd1, 32'd0, 8'd0);
        expect_rsp("t2_pop_back", 1'b0, c_a, 8'd1);
        check("t2_cnt",   64'(bus.cnt_r),   64'h0000_0100);
        check("t2_empty", 64'(bus.empty_r), 64'hD);

        // 4: pop on an empty queue is rejected, flags untouched
        do_cmd(OP_POP_FRONT, 2'd2, 32'd0, 8'd0);
        expect_rsp("t4_pop_empty", 1'b1, 32'd0, 8'd0);
        check("t4_empty", 64'(bus.empty_r), 64'hD);
        check("t4_cnt",   64'(bus.cnt_r),   64'h0000_0100);

        // DELETE of the remaining id1 entry (B at ptr 2)
`ifdef DLL_MQ_DELETE_EN
        do_cmd(OP_DELETE, 2'd1, 32'd0, 8'd2);
        expect_rsp("del_b", 1'b0, c_b, 8'd2);
`else
        do_cmd(OP_DELETE, 2'd1, 32'd0, 8'd2);
        expect_rsp("del_disabled", 1'b1, 32'd0, 8'd0);
        check("del_disabled_cnt", 64'(bus.cnt_r), 64'h0000_0100);
        do_cmd(OP_POP_FRONT, 2'd1, 32'd0, 8'd0);
        expect_rsp("drain_b", 1'b0, c_b, 8'd2);
`endif
        check("drain_empty", 64'(bus.empty_r), 64'hF);

        // Undefined opcodes are always rejected
        do_cmd(op_t'(3'd5), 2'd0, c_a, 8'd1);
        expect_rsp("op5", 1'b1, 32'd0, 8'd0);
        do_cmd(op_t'(3'd7), 2'd3, c_a, 8'd0);
        expect_rsp("op7", 1'b1, 32'd0, 8'd0);
        check("op_bad_empty", 64'(bus.empty_r), 64'hF);

`ifdef DLL_MQ_DELETE_EN
        // 5: unlink from the middle, then both ends
        do_cmd(OP_PUSH_BACK, 2'd3, c_a, 8'd0);
        expect_rsp("t5_push_a", 1'b0, 32'd0, 8'd1);
        do_cmd(OP_PUSH_BACK, 2'd3, c_b, 8'd0);
        expect_rsp("t5_push_b", 1'b0, 32'd0, 8'd2);
        do_cmd(OP_PUSH_BACK, 2'd3, c_c, 8'd0);
        expect_rsp("t5_push_c", 1'b0, 32'd0, 8'd3);
        do_cmd(OP_DELETE, 2'd3, 32'd0, 8'd2);
        expect_rsp("t5_del_mid", 1'b0, c_b, 8'd2);
        check("t5_cnt", 64'(bus.cnt_r), 64'h0200_0000);
        do_cmd(OP_DELETE, 2'd0, 32'd0, 8'd1);
        expect_rsp("t5_del_owner", 1'b1, 32'd0, 8'd0);
        do_cmd(OP_DELETE, 2'd3, 32'd0, 8'd2);
        expect_rsp("t5_del_free", 1'b1, 32'd0, 8'd0);
        do_cmd(OP_DELETE, 2'd3, 32'd0, 8'd0);
        expect_rsp("t5_del_null", 1'b1, 32'd0, 8'd0);
        do_cmd(OP_POP_FRONT, 2'd3, 32'd0, 8'd0);
        expect_rsp("t5_pop_front", 1'b0, c_a, 8'd1);
        do_cmd(OP_POP_BACK, 2'd3, 32'd0, 8'd0);
        expect_rsp("t5_pop_back", 1'b0, c_c, 8'd3);
        check("t5_empty", 64'(bus.empty_r), 64'hF);
`endif

        // 3: fill the pool across all queues
        for (int i = 0; i < 255; i++) begin
            do_cmd(OP_PUSH_BACK, 2'(i % 4), 32'(i), 8'd0);
            check("t3_fill_ptr", 64'(got_ptr), 64'(i + 1));
        end
        check("t3_full",  64'(bus.full_r), 64'd1);
        check("t3_cnt",   64'(bus.cnt_r),  64'h3F40_4040);
        do_cmd(OP_PUSH_FRONT, 2'd0, c_a, 8'd0);
        expect_rsp("t3_push_full", 1'b1, 32'd0, 8'd0);
        check("t3_cnt_kept", 64'(bus.cnt_r), 64'h3F40_4040);
        do_cmd(OP_POP_FRONT, 2'd2, 32'd0, 8'd0);
        expect_rsp("t3_pop", 1'b0, 32'd2, 8'd3);
        check("t3_not_full", 64'(bus.full_r), 64'd0);
        do_cmd(OP_PUSH_BACK, 2'd3, c_c, 8'd0);
        expect_rsp("t3_reuse", 1'b0, 32'd0, 8'd3);
        check("t3_full_again", 64'(bus.full_r), 64'd1);

        // 6: reset while a command is in LINK
        bus.cmd_vld = 1'b1;
        bus.cmd_op  = OP_POP_BACK;
        bus.cmd_id  = 2'd0;
        bus.cmd_dat = '0;
        bus.cmd_ptr = '0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_vld = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_no_rsp", 64'(bus.rsp_vld), 64'd0);
        check("t6_rdy",    64'(bus.cmd_rdy), 64'd1);
        check("t6_empty",  64'(bus.empty_r), 64'hF);
        check("t6_full",   64'(bus.full_r),  64'd0);
        check("t6_cnt",    64'(bus.cnt_r),   64'd0);
        do_cmd(OP_PUSH_BACK, 2'd2, c_a, 8'd0);
        expect_rsp("t6_push", 1'b0, 32'd0, 8'd1);
        check("t6_cnt_after", 64'(bus.cnt_r), 64'h0001_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
